// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 keyboard frame receiver feeding a first-word-fall-through
//               byte FIFO with overflow and frame-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int                c_AW       = $clog2(FIFO_DEPTH);
    localparam int                c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_AW:0]     c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_TO_W-1:0] c_TO_MAX   = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]        c_STOP_IDX = 4'd10;

    logic              r_clk_s1, r_clk_s2, r_clk_prev;
    logic              r_dat_s1, r_dat_s2;
    logic [9:0]        r_shift;
    logic [3:0]        r_bit_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_frame_err;
    logic              r_overflow;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic w_fall, w_eval, w_frame_ok, w_push, w_bad, w_timeout;
    logic w_pop, w_full, w_wr, w_drop;

    // Lines idle high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_eval = w_fall && (r_bit_cnt == c_STOP_IDX);

    // Shift register holds start at [0], d0..d7 at [8:1], parity at [9];
    // the stop bit is taken straight from the synchroniser.
    assign w_frame_ok = ~r_shift[0] & r_dat_s2 & (^r_shift[9:1]);
    assign w_push     = w_eval & w_frame_ok;
    assign w_bad      = w_eval & ~w_frame_ok;
    assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == c_TO_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_fall) begin
            if (w_eval) begin
                r_bit_cnt <= '0;
            end else begin
                r_shift   <= {r_dat_s2, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else if (w_timeout) begin
            r_bit_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_bit_cnt == 4'd0) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad | w_timeout;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pop  = rd_en && (r_count != '0);
    assign w_full = (r_count == c_DEPTH);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign data      = r_mem[r_rd_ptr];
    assign ready     = (r_count != '0);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Randomized frame-level bench for ps2_rx_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int c_DEPTH = 8;
    localparam int c_TO    = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (c_DEPTH),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .ready     (ready),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       failures = 0;
    logic [7:0] m_q[$];
    bit       m_ovf = 1'b0;
    int       m_errs = 0;
    int       err_seen = 0;
    int       err_run = 0;
    int       err_run_max = 0;
    int       half = 20;
    time      t_last_fall = 0;

    // Count frame_err pulses and track the longest run of consecutive highs.
    always @(negedge clk) begin
        err_seen <= err_seen + (frame_err ? 1 : 0);
        err_run  <= frame_err ? err_run + 1 : 0;
        if (frame_err && (err_run + 1 > err_run_max)) err_run_max <= err_run + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".ready"}, 32'(ready), 32'(m_q.size() > 0));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".errs"}, 32'(err_seen), 32'(m_errs));
        if (m_q.size() > 0) check({tag, ".data"}, 32'(data), 32'(m_q[0]));
    endtask

    // Drive bits LSB first; optionally raise rd_en exactly in the push cycle.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_push);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            t_last_fall = $time;
            if (pop_at_push && i == nbits - 1) begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (half - 2) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        if (kind == 1) par = ~par;
        return {(kind == 3) ? 1'b0 : 1'b1, par, b, (kind == 2) ? 1'b1 : 1'b0};
    endfunction

    task automatic frame(input string tag, input logic [7:0] b, input int kind, input bit pop_at_push);
        if (pop_at_push && m_q.size() > 0) void'(m_q.pop_front());
        if (kind == 0) begin
            if (m_q.size() < c_DEPTH) m_q.push_back(b);
            else m_ovf = 1'b1;
        end else begin
            m_errs++;
        end
        send_bits(make_frame(b, kind), 11, pop_at_push);
        repeat (6) @(negedge clk);
        compare_state(tag);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        if (m_q.size() > 0) check({tag, ".head"}, 32'(data), 32'(m_q[0]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".ready"}, 32'(ready), 32'(m_q.size() > 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int waited;
        int elapsed;
        repeat (4) @(negedge clk);
        check("reset.count", 32'(count), 0);
        check("reset.ready", 32'(ready), 0);
        check("reset.overflow", 32'(overflow), 0);
        check("reset.frame_err", 32'(frame_err), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        frame("single", 8'h1C, 0, 1'b0);
        pop_one("single_pop");
        pop_one("empty_pop");

        frame("bad_parity", 8'h1C, 1, 1'b0);
        frame("bad_stop", 8'h55, 3, 1'b0);
        frame("bad_start", 8'h33, 2, 1'b0);
        frame("after_bad", 8'hF0, 0, 1'b0);
        pop_one("after_bad_pop");

        for (int i = 1; i <= 9; i++) frame("fill", 8'(i), 0, 1'b0);
        for (int i = 0; i < 8; i++) pop_one("drain");

        do_reset();
        for (int i = 0; i < 8; i++) frame("refill", 8'(8'h10 + i), 0, 1'b0);
        frame("full_push_pop", 8'hAA, 0, 1'b1);
        for (int i = 0; i < 8; i++) pop_one("drain2");

        // Partial frame: frame_err must arrive about TIMEOUT cycles after the last fall.
        half = 20;
        send_bits(11'h0AA, 5, 1'b0);
        waited = 0;
        while (err_seen == m_errs && waited < c_TO + 100) begin
            @(negedge clk);
            waited++;
        end
        elapsed = int'(($time - t_last_fall) / 10);
        m_errs++;
        check("timeout.window", 32'((elapsed >= c_TO) && (elapsed <= c_TO + 10)), 1);
        repeat (4) @(negedge clk);
        compare_state("timeout");
        frame("after_timeout", 8'h29, 0, 1'b0);

        frame("pre_reset", 8'h5A, 0, 1'b0);
        send_bits(11'h155, 4, 1'b0);
        do_reset();
        check("midreset.frame_err", 32'(frame_err), 0);
        compare_state("midreset");
        frame("post_reset", 8'h29, 0, 1'b0);
        pop_one("post_reset_pop");

        for (int it = 0; it < 40; it++) begin
            int kind;
            int npops;
            half = int'($urandom_range(15, 30));
            kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            frame("rand", 8'($urandom), kind, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            npops = int'($urandom_range(0, 2));
            for (int p = 0; p < npops; p++) pop_one("rand_pop");
        end

        check("err_pulse_width", 32'(err_run_max), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
